spram_arbiter: RTL and testbench
================================

Name: spram_arbiter

Overview:
Two-master arbiter and sequencer for a 32-bit memory built from a pair of 16-bit iCE40 SPRAM256KA macros (lo half = bits 15:0, hi half = bits 31:16). It shares the macros between requester A (CPU) and requester B (loader/DMA) using req/ack with round-robin fairness. It converts byte enables to SPRAM nibble masks and drives chip select. It also puts the macros into standby after an idle period and sequences the wake-up before the next access.

Parameters:
IDLE_STBY, 16, number of consecutive idle cycles in IDLE before entering STBY; 0 disables standby
WAKE_CYC, 3, cycles spent in WAKE (standby deasserted, no access) before an access may be issued; must be >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active high
a_req  in  1  A request; held high until a_ack
a_we  in  1  A write (1) / read (0); stable while a_req
a_adr  in  14  A word address
a_wdat  in  32  A write data
a_be  in  4  A byte enables
a_ack  out  1  one-cycle A completion pulse
a_rdat  out  32  A read data, valid only while a_ack
b_req, b_we, b_adr, b_wdat, b_be, b_ack, b_rdat  same as A, for requester B
sp_address  out  14  to both macros ADDRESS
sp_datain_lo  out  16  to lo macro DATAIN
sp_datain_hi  out  16  to hi macro DATAIN
sp_maskwren_lo  out  4  to lo MASKWREN
sp_maskwren_hi  out  4  to hi MASKWREN
sp_wren  out  1  to both WREN
sp_cs  out  1  to both CHIPSELECT
sp_standby  out  1  to both STANDBY (SLEEP tied 0, POWEROFF tied 1 outside this block)
sp_dataout_lo  in  16  from lo DATAOUT
sp_dataout_hi  in  16  from hi DATAOUT

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- States: IDLE, CMD, RESP, STBY, WAKE.
- Reset: state IDLE, all sp_* outputs 0, a_ack = b_ack = 0, idle counter 0, round-robin pointer "B last", so A wins the first tie. Reset during CMD or RESP aborts the access. No ack is issued for it. The requester must re-request.
- All sp_* outputs are registered. Their values are loaded on the transition into CMD.
- IDLE, when any req is high: grant a requester, load the sp_* registers, set sp_cs = 1, go to CMD.
- Tie rule: if both reqs are high, grant the requester that was not last granted. Update the pointer on every grant.
- CMD, 1 cycle: the macros sample on the edge ending CMD. Next state RESP, with sp_cs, sp_wren and the masks cleared on that edge.
- RESP, 1 cycle: the granted requester's ack = 1. rdat = {sp_dataout_hi, sp_dataout_lo}, passed through combinationally. rdat is don't-care outside ack.
- Leaving RESP: if the other requester's req is high, grant it and go straight to CMD. Otherwise go to IDLE. The just-acked requester is never regranted in RESP, because its req may still be high in that cycle.
- Latency: req high in IDLE cycle n gives ack in cycle n+2. Peak throughput is 1 access per 2 cycles when alternating, 1 per 3 for a single master.
- Write: sp_wren = we. The nibble masks are:
  - sp_maskwren_lo = {be[1], be[1], be[0], be[0]}
  - sp_maskwren_hi = {be[3], be[3], be[2], be[2]}
- A write with be = 0 modifies nothing but is still acked.
- Read: sp_wren = 0, masks = 0.
- sp_datain_lo = wdat[15:0], sp_datain_hi = wdat[31:16].
- Idle counter:
  - Increments each cycle in IDLE with no req.
  - Clears on any req, and in every other state.
  - When IDLE_STBY != 0 and the counter reaches IDLE_STBY-1 with no req, the next state is STBY.
- STBY: sp_standby = 1, sp_cs = 0, requests are not acked. Any req moves the block to WAKE on the next edge, with sp_standby = 0.
- WAKE: lasts exactly WAKE_CYC cycles, then IDLE, where normal arbitration applies.
  - Latency from a req in STBY cycle n: ack in cycle n+WAKE_CYC+3.
- Requests that drop before ack are a protocol violation. Behaviour is undefined; no checking is required.

Test Plan:
- Read: preload mem[0x0123] = 0xBEEF (lo) and 0xCAFE (hi); A reads 0x0123 in IDLE at cycle 0 -> sp_cs = 1 in cycle 1, a_ack in cycle 2, a_rdat = 0xCAFEBEEF, b_ack never asserted.
- Byte-enable write: mem[0x10] = 0x00000000; B writes 0x11223344 with be = 0101, then reads -> sp_maskwren_lo = 0011, sp_maskwren_hi = 0011, readback 0x00220044.
- Contention: a_req and b_req held high continuously for 4 accesses from reset -> grant order A, B, A, B; acks at cycles 2, 4, 6, 8.
- Standby: after the last ack, 16 idle cycles -> sp_standby = 1 in idle cycle 17. A req in STBY cycle n -> sp_standby = 0 at n+1, a_ack at n+6 with WAKE_CYC = 3. The data read is correct.
- Reset mid-access: rst asserted in CMD of an A write to 0x0005 -> no a_ack; all sp_* = 0 the next cycle; state IDLE; after reset a B request is acked 2 cycles later.
- IDLE_STBY = 0: 100 idle cycles -> sp_standby never asserted.

Source files
------------

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-master round-robin arbiter and standby sequencer for a 32-bit SPRAM pair
module spram_arbiter #(
    parameter int IDLE_STBY = 16,
    parameter int WAKE_CYC  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [13:0] a_adr,
    input  logic [31:0] a_wdat,
    input  logic [3:0]  a_be,
    output logic        a_ack,
    output logic [31:0] a_rdat,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [13:0] b_adr,
    input  logic [31:0] b_wdat,
    input  logic [3:0]  b_be,
    output logic        b_ack,
    output logic [31:0] b_rdat,
    output logic [13:0] sp_address,
    output logic [15:0] sp_datain_lo,
    output logic [15:0] sp_datain_hi,
    output logic [3:0]  sp_maskwren_lo,
    output logic [3:0]  sp_maskwren_hi,
    output logic        sp_wren,
    output logic        sp_cs,
    output logic        sp_standby,
    input  logic [15:0] sp_dataout_lo,
    input  logic [15:0] sp_dataout_hi
);
    localparam int CW = (IDLE_STBY > 1) ? $clog2(IDLE_STBY) : 1;
    localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_RESP, S_STBY, S_WAKE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [WW-1:0] wake_cnt_q, wake_cnt_d;
    logic          gnt_b_q, gnt_b_d;
    logic          last_b_q, last_b_d;
    logic [13:0]   sp_address_q, sp_address_d;
    logic [15:0]   sp_datain_lo_q, sp_datain_lo_d;
    logic [15:0]   sp_datain_hi_q, sp_datain_hi_d;
    logic [3:0]    sp_maskwren_lo_q, sp_maskwren_lo_d;
    logic [3:0]    sp_maskwren_hi_q, sp_maskwren_hi_d;
    logic          sp_wren_q, sp_wren_d;
    logic          sp_cs_q, sp_cs_d;
    logic          sp_standby_q, sp_standby_d;
    logic          load, load_b;
    logic          sel_we;
    logic [13:0]   sel_adr;
    logic [31:0]   sel_wdat;
    logic [3:0]    sel_be;

    always_comb begin
        state_d          = state_q;
        idle_cnt_d       = '0;
        wake_cnt_d       = '0;
        gnt_b_d          = gnt_b_q;
        last_b_d         = last_b_q;
        sp_address_d     = sp_address_q;
        sp_datain_lo_d   = sp_datain_lo_q;
        sp_datain_hi_d   = sp_datain_hi_q;
        sp_maskwren_lo_d = sp_maskwren_lo_q;
        sp_maskwren_hi_d = sp_maskwren_hi_q;
        sp_wren_d        = sp_wren_q;
        sp_cs_d          = sp_cs_q;
        sp_standby_d     = sp_standby_q;
        load             = 1'b0;
        load_b           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (a_req || b_req) begin
                    load    = 1'b1;
                    load_b  = (a_req && b_req) ? !last_b_q : b_req;
                    state_d = S_CMD;
                end else if ((IDLE_STBY != 0) && (idle_cnt_q == CW'(IDLE_STBY - 1))) begin
                    state_d      = S_STBY;
                    sp_standby_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end
            S_CMD: begin
                state_d          = S_RESP;
                sp_cs_d          = 1'b0;
                sp_wren_d        = 1'b0;
                sp_maskwren_lo_d = 4'b0000;
                sp_maskwren_hi_d = 4'b0000;
            end
            S_RESP: begin
                // Only the other master may be granted here; the acked one may still hold req.
                if (gnt_b_q ? a_req : b_req) begin
                    load    = 1'b1;
                    load_b  = !gnt_b_q;
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STBY: begin
                if (a_req || b_req) begin
                    state_d      = S_WAKE;
                    sp_standby_d = 1'b0;
                end
            end
            S_WAKE: begin
                if (wake_cnt_q == WW'(WAKE_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    wake_cnt_d = wake_cnt_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        sel_we   = load_b ? b_we   : a_we;
        sel_adr  = load_b ? b_adr  : a_adr;
        sel_wdat = load_b ? b_wdat : a_wdat;
        sel_be   = load_b ? b_be   : a_be;

        if (load) begin
            gnt_b_d          = load_b;
            last_b_d         = load_b;
            sp_address_d     = sel_adr;
            sp_datain_lo_d   = sel_wdat[15:0];
            sp_datain_hi_d   = sel_wdat[31:16];
            sp_wren_d        = sel_we;
            sp_maskwren_lo_d = sel_we ? {sel_be[1], sel_be[1], sel_be[0], sel_be[0]} : 4'b0000;
            sp_maskwren_hi_d = sel_we ? {sel_be[3], sel_be[3], sel_be[2], sel_be[2]} : 4'b0000;
            sp_cs_d          = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            idle_cnt_q       <= '0;
            wake_cnt_q       <= '0;
            gnt_b_q          <= 1'b0;
            last_b_q         <= 1'b1;
            sp_address_q     <= '0;
            sp_datain_lo_q   <= '0;
            sp_datain_hi_q   <= '0;
            sp_maskwren_lo_q <= '0;
            sp_maskwren_hi_q <= '0;
            sp_wren_q        <= 1'b0;
            sp_cs_q          <= 1'b0;
            sp_standby_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            idle_cnt_q       <= idle_cnt_d;
            wake_cnt_q       <= wake_cnt_d;
            gnt_b_q          <= gnt_b_d;
            last_b_q         <= last_b_d;
            sp_address_q     <= sp_address_d;
            sp_datain_lo_q   <= sp_datain_lo_d;
            sp_datain_hi_q   <= sp_datain_hi_d;
            sp_maskwren_lo_q <= sp_maskwren_lo_d;
            sp_maskwren_hi_q <= sp_maskwren_hi_d;
            sp_wren_q        <= sp_wren_d;
            sp_cs_q          <= sp_cs_d;
            sp_standby_q     <= sp_standby_d;
        end
    end

    assign sp_address     = sp_address_q;
    assign sp_datain_lo   = sp_datain_lo_q;
    assign sp_datain_hi   = sp_datain_hi_q;
    assign sp_maskwren_lo = sp_maskwren_lo_q;
    assign sp_maskwren_hi = sp_maskwren_hi_q;
    assign sp_wren        = sp_wren_q;
    assign sp_cs          = sp_cs_q;
    assign sp_standby     = sp_standby_q;

    assign a_ack  = (state_q == S_RESP) && !gnt_b_q;
    assign b_ack  = (state_q == S_RESP) && gnt_b_q;
    assign a_rdat = {sp_dataout_hi, sp_dataout_lo};
    assign b_rdat = {sp_dataout_hi, sp_dataout_lo};
endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed bench for spram_arbiter with a behavioural SPRAM pair
module tb_spram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [13:0] a_adr = '0, b_adr = '0;
    logic [31:0] a_wdat = '0, b_wdat = '0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic        a_ack, b_ack;
    logic [31:0] a_rdat, b_rdat;
    logic [13:0] sp_address;
    logic [15:0] sp_datain_lo, sp_datain_hi, sp_dataout_lo, sp_dataout_hi;
    logic [3:0]  sp_maskwren_lo, sp_maskwren_hi;
    logic        sp_wren, sp_cs, sp_standby;

    logic        u1_a_ack, u1_b_ack, u1_wren, u1_cs, u1_standby;
    logic [31:0] u1_a_rdat, u1_b_rdat;
    logic [13:0] u1_address;
    logic [15:0] u1_din_lo, u1_din_hi;
    logic [3:0]  u1_mlo, u1_mhi;
    logic        u1_stby_seen = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.IDLE_STBY(16), .WAKE_CYC(3)) u0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdat(a_wdat), .a_be(a_be),
        .a_ack(a_ack), .a_rdat(a_rdat),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdat(b_wdat), .b_be(b_be),
        .b_ack(b_ack), .b_rdat(b_rdat),
        .sp_address(sp_address), .sp_datain_lo(sp_datain_lo), .sp_datain_hi(sp_datain_hi),
        .sp_maskwren_lo(sp_maskwren_lo), .sp_maskwren_hi(sp_maskwren_hi),
        .sp_wren(sp_wren), .sp_cs(sp_cs), .sp_standby(sp_standby),
        .sp_dataout_lo(sp_dataout_lo), .sp_dataout_hi(sp_dataout_hi)
    );

    spram_arbiter #(.IDLE_STBY(0), .WAKE_CYC(3)) u1 (
        .clk(clk), .rst(rst),
        .a_req(1'b0), .a_we(1'b0), .a_adr(14'h0), .a_wdat(32'h0), .a_be(4'h0),
        .a_ack(u1_a_ack), .a_rdat(u1_a_rdat),
        .b_req(1'b0), .b_we(1'b0), .b_adr(14'h0), .b_wdat(32'h0), .b_be(4'h0),
        .b_ack(u1_b_ack), .b_rdat(u1_b_rdat),
        .sp_address(u1_address), .sp_datain_lo(u1_din_lo), .sp_datain_hi(u1_din_hi),
        .sp_maskwren_lo(u1_mlo), .sp_maskwren_hi(u1_mhi),
        .sp_wren(u1_wren), .sp_cs(u1_cs), .sp_standby(u1_standby),
        .sp_dataout_lo(16'h0), .sp_dataout_hi(16'h0)
    );

    always @(negedge clk) if (u1_standby) u1_stby_seen = 1'b1;

    // Behavioural SPRAM pair: samples on the rising edge while selected, nibble-masked writes.
    logic [15:0] mem_lo [0:16383];
    logic [15:0] mem_hi [0:16383];
    initial begin
        logic [15:0] tlo, thi;
        for (int i = 0; i < 16384; i++) begin
            mem_lo[i] = '0;
            mem_hi[i] = '0;
        end
        mem_lo[14'h0123] = 16'hBEEF; mem_hi[14'h0123] = 16'hCAFE;
        mem_lo[14'h3FFF] = 16'hBEEF; mem_hi[14'h3FFF] = 16'hDEAD;
        sp_dataout_lo = '0;
        sp_dataout_hi = '0;
        forever begin
            @(posedge clk);
            if (sp_cs) begin
                if (sp_wren) begin
                    tlo = mem_lo[sp_address];
                    thi = mem_hi[sp_address];
                    for (int n = 0; n < 4; n++) begin
                        if (sp_maskwren_lo[n]) tlo[4*n +: 4] = sp_datain_lo[4*n +: 4];
                        if (sp_maskwren_hi[n]) thi[4*n +: 4] = sp_datain_hi[4*n +: 4];
                    end
                    mem_lo[sp_address] = tlo;
                    mem_hi[sp_address] = thi;
                end else begin
                    sp_dataout_lo <= mem_lo[sp_address];
                    sp_dataout_hi <= mem_hi[sp_address];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic is_b, input logic we, input logic [13:0] adr,
                           input logic [31:0] wdat, input logic [3:0] be);
        if (is_b) begin
            b_req = 1'b1; b_we = we; b_adr = adr; b_wdat = wdat; b_be = be;
        end else begin
            a_req = 1'b1; a_we = we; a_adr = adr; a_wdat = wdat; a_be = be;
        end
    endtask

    typedef struct {
        logic        is_b;
        logic        we;
        logic [13:0] adr;
        logic [31:0] wdat;
        logic [3:0]  be;
        logic [3:0]  exp_mlo;
        logic [3:0]  exp_mhi;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    // Starts in an IDLE cycle, ends one cycle after the ack with the DUT back in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        logic own_ack, oth_ack;
        logic [31:0] rd;
        set_req(v.is_b, v.we, v.adr, v.wdat, v.be);
        tick();
        chk($sformatf("v%0d cs", idx), {31'b0, sp_cs}, 32'd1);
        chk($sformatf("v%0d wren", idx), {31'b0, sp_wren}, {31'b0, v.we});
        chk($sformatf("v%0d addr", idx), {18'b0, sp_address}, {18'b0, v.adr});
        chk($sformatf("v%0d mask_lo", idx), {28'b0, sp_maskwren_lo}, {28'b0, v.exp_mlo});
        chk($sformatf("v%0d mask_hi", idx), {28'b0, sp_maskwren_hi}, {28'b0, v.exp_mhi});
        if (v.we) chk($sformatf("v%0d datain", idx), {sp_datain_hi, sp_datain_lo}, v.wdat);
        tick();
        own_ack = v.is_b ? b_ack : a_ack;
        oth_ack = v.is_b ? a_ack : b_ack;
        rd      = v.is_b ? b_rdat : a_rdat;
        chk($sformatf("v%0d ack", idx), {31'b0, own_ack}, 32'd1);
        chk($sformatf("v%0d other_ack", idx), {31'b0, oth_ack}, 32'd0);
        chk($sformatf("v%0d resp_cs", idx), {31'b0, sp_cs}, 32'd0);
        if (v.chk_rd) chk($sformatf("v%0d rdat", idx), rd, v.exp_rd);
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        chk($sformatf("v%0d ack_pulse", idx), {30'b0, a_ack, b_ack}, 32'd0);
    endtask

    initial begin
        int acked_a, acked_b;
        logic [31:0] exp_a, exp_b;

        vecs[0]  = '{1'b0, 1'b0, 14'h0123, 32'h0,        4'h0, 4'h0, 4'h0, 1'b1, 32'hCAFEBEEF};
        vecs[1]  = '{1'b1, 1'b1, 14'h0010, 32'h11223344, 4'h5, 4'h3, 4'h3, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 14'h0010, 32'h0,        4'h0, 4'h0, 4'h0, 1'b1, 32'h00220044};
        vecs[3]  = '{1'b0, 1'b1, 14'h0020, 32'hAABBCCDD, 4'hF, 4'hF, 4'hF, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 14'h0020, 32'h0,        4'h0, 4'h0, 4'h0, 1'b1, 32'hAABBCCDD};
        vecs[5]  = '{1'b0, 1'b1, 14'h0020, 32'h55667788, 4'hA, 4'hC, 4'hC, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 14'h0020, 32'h0,        4'h0, 4'h0, 4'h0, 1'b1, 32'h55BB77DD};
        vecs[7]  = '{1'b1, 1'b1, 14'h3FFF, 32'h12345678, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 14'h3FFF, 32'h0,        4'h0, 4'h0, 4'h0, 1'b1, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 1'b1, 14'h3FFF, 32'h9A000000, 4'h8, 4'h0, 4'hC, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 14'h3FFF, 32'h0,        4'h0, 4'h0, 4'h0, 1'b1, 32'h9AADBEEF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset sp_bus", {sp_address, sp_datain_lo[1:0]}, 16'h0);
        chk("reset datain", {sp_datain_hi, sp_datain_lo}, 32'h0);
        chk("reset ctl", {24'b0, sp_maskwren_lo, sp_maskwren_hi} | {29'b0, sp_wren, sp_cs, sp_standby}, 32'h0);
        chk("reset acks", {30'b0, a_ack, b_ack}, 32'd0);

        // Contention from reset: A wins the first tie, then strict alternation.
        rst = 1'b0;
        set_req(1'b0, 1'b0, 14'h0123, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
        acked_a = 0;
        acked_b = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            exp_a = (cyc == 2 || cyc == 6) ? 32'd1 : 32'd0;
            exp_b = (cyc == 4 || cyc == 8) ? 32'd1 : 32'd0;
            chk($sformatf("cont c%0d a_ack", cyc), {31'b0, a_ack}, exp_a);
            chk($sformatf("cont c%0d b_ack", cyc), {31'b0, b_ack}, exp_b);
            chk($sformatf("cont c%0d cs", cyc), {31'b0, sp_cs}, {31'b0, cyc[0]});
            if (a_ack) chk("cont a_rdat", a_rdat, 32'hCAFEBEEF);
            if (b_ack) chk("cont b_rdat", b_rdat, 32'h00000000);
        end
        a_req = 1'b0;
        b_req = 1'b0;

        // Standby entry after 16 idle cycles, then wake on an A read.
        for (int k = 1; k <= 16; k++) tick();
        chk("stby idle16", {31'b0, sp_standby}, 32'd0);
        tick();
        chk("stby idle17", {31'b0, sp_standby}, 32'd1);
        tick();
        chk("stby held", {30'b0, sp_standby, sp_cs}, 32'd2);
        set_req(1'b0, 1'b0, 14'h0123, 32'h0, 4'h0);
        tick();
        chk("wake standby", {31'b0, sp_standby}, 32'd0);
        chk("wake cs", {31'b0, sp_cs}, 32'd0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("wake n+%0d a_ack", k), {31'b0, a_ack}, 32'd0);
            chk($sformatf("wake n+%0d cs", k), {31'b0, sp_cs}, (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        chk("wake a_ack", {31'b0, a_ack}, 32'd1);
        chk("wake a_rdat", a_rdat, 32'hCAFEBEEF);
        a_req = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset in CMD of an A write: aborted, no ack, bus cleared, B served right after.
        set_req(1'b0, 1'b1, 14'h0005, 32'hFFFFFFFF, 4'hF);
        tick();
        chk("rst_mid cmd cs", {31'b0, sp_cs}, 32'd1);
        rst = 1'b1;
        a_req = 1'b0;
        tick();
        chk("rst_mid a_ack", {31'b0, a_ack}, 32'd0);
        chk("rst_mid bus", {sp_address, sp_datain_lo, sp_datain_hi[1:0]}, 32'h0);
        chk("rst_mid ctl", {24'b0, sp_maskwren_lo, sp_maskwren_hi} | {29'b0, sp_wren, sp_cs, sp_standby}, 32'h0);
        rst = 1'b0;
        set_req(1'b1, 1'b0, 14'h0123, 32'h0, 4'h0);
        tick();
        chk("rst_mid b cmd", {30'b0, sp_cs, b_ack}, 32'd2);
        tick();
        chk("rst_mid b_ack", {30'b0, a_ack, b_ack}, 32'd1);
        chk("rst_mid b_rdat", b_rdat, 32'hCAFEBEEF);
        b_req = 1'b0;
        tick();

        repeat (100) @(posedge clk);
        #1;
        chk("idle_stby0 never standby", {31'b0, u1_stby_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
